xmas_light_sequencer: RTL and testbench

Pattern scheduler for the 8-LED Christmas-tree display inside tt_um_ChristmasTree_MaligayangPasko. It drives uo_out-class LED lines through four light-show modes: chase, fill, blink and sparkle. Each 8-step frame is paced by a programmable prescaler. Run, mode, auto-cycle and speed come from ui_in bits decoded in the top level.

---
 rtl/xmas_light_sequencer.sv | 154 +++++++++++++++
 tb/tb_xmas_light_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xmas_light_sequencer.sv
// Light-show scheduler for the 8-LED tree: steps chase/fill/blink/sparkle frames
// at a prescaled rate, optionally rotating through the modes frame by frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | LEDs dark, prescaler and step cleared, waiting for run
// ST_RUN  | show active; prescaler paces steps 0..7 of the current frame
module xmas_light_sequencer #(
  parameter int         TICK_DIV = 4,
  parameter logic [7:0] SEED     = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       auto_cycle,
  input  logic [1:0] speed,
  output logic [7:0] leds,
  output logic       step_pulse,
  output logic       frame_done,
  output logic       busy
);

  localparam int CNT_W = $clog2(TICK_DIV * 8 + 1);

  localparam logic [1:0] MODE_CHASE   = 2'd0;
  localparam logic [1:0] MODE_FILL    = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_SPARKLE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       leds_q, leds_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             step_pulse_q, step_pulse_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] period_m1;
  logic             tick;
  logic [7:0]       lfsr_next;
  logic [1:0]       next_mode;

  // Sparkle frames take whatever the LFSR holds once this edge's advance is applied.
  function automatic logic [7:0] frame_f(input logic [1:0] m, input logic [2:0] s,
                                         input logic [7:0] spark);
    logic [7:0] f;
    case (m)
      MODE_CHASE: f = 8'h01 << s;
      MODE_FILL:  f = 8'hFF >> (3'd7 - s);
      MODE_BLINK: f = s[0] ? 8'h55 : 8'hAA;
      default:    f = spark;
    endcase
    return f;
  endfunction

  assign period_m1 = (CNT_W'(TICK_DIV) << speed) - CNT_W'(1);
  // >= rather than == so a speed increase mid-step cannot strand cnt above the limit.
  assign tick      = (cnt_q >= period_m1);
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d      = state_q;
    leds_d       = leds_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    cur_mode_d   = cur_mode_q;
    lfsr_d       = lfsr_q;
    step_pulse_d = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    next_mode    = auto_cycle ? (cur_mode_q + 2'd1) : mode;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          leds_d = 8'h00;
          cnt_d  = '0;
          step_d = 3'd0;
          if (run) begin
            state_d    = ST_RUN;
            cur_mode_d = mode;
            leds_d     = frame_f(mode, 3'd0, lfsr_q);
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_d = ST_IDLE;
            leds_d  = 8'h00;
            cnt_d   = '0;
            step_d  = 3'd0;
          end else if (tick) begin
            cnt_d        = '0;
            step_pulse_d = 1'b1;
            if (cur_mode_q == MODE_SPARKLE) begin
              lfsr_d = lfsr_next;
            end
            if (step_q != 3'd7) begin
              step_d = step_q + 3'd1;
              leds_d = frame_f(cur_mode_q, step_q + 3'd1, lfsr_d);
            end else begin
              frame_done_d = 1'b1;
              step_d       = 3'd0;
              cur_mode_d   = next_mode;
              leds_d       = frame_f(next_mode, 3'd0, lfsr_d);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      leds_q       <= 8'h00;
      step_q       <= 3'd0;
      cnt_q        <= '0;
      cur_mode_q   <= MODE_CHASE;
      lfsr_q       <= SEED;
      step_pulse_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      leds_q       <= leds_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      cur_mode_q   <= cur_mode_d;
      lfsr_q       <= lfsr_d;
      step_pulse_q <= step_pulse_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_pulse_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_xmas_light_sequencer.sv
// Self-checking bench for xmas_light_sequencer: a behavioural model pushes the
// expected outputs of every edge into a scoreboard, plus fixed pattern tables.
module tb_xmas_light_sequencer;

  localparam int         TICK_DIV = 4;
  localparam logic [7:0] SEED     = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n, ena, run, auto_cycle;
  logic [1:0] mode, speed;
  logic [7:0] leds;
  logic       step_pulse, frame_done, busy;

  xmas_light_sequencer #(.TICK_DIV(TICK_DIV), .SEED(SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .run        (run),
    .mode       (mode),
    .auto_cycle (auto_cycle),
    .speed      (speed),
    .leds       (leds),
    .step_pulse (step_pulse),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] leds;
    logic       sp;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] obs_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_cnt = 0;
  int         last_pulse_at = 0;
  int         last_gap = 0;

  logic       m_run, m_sp, m_fd;
  logic [7:0] m_leds, m_lfsr;
  logic [2:0] m_step;
  logic [1:0] m_mode;
  int         m_cnt;

  logic [7:0] chase_tbl [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] fill_tbl  [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
  logic [7:0] spark_tbl [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_frame(input logic [1:0] m, input logic [2:0] s);
    logic [7:0] v;
    v = 8'h00;
    case (m)
      2'd0: v[s] = 1'b1;
      2'd1: for (int i = 0; i < 8; i++) if (i <= int'(s)) v[i] = 1'b1;
      default: v = s[0] ? 8'h55 : 8'hAA;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] ref_lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_edge();
    exp_t       e;
    logic [1:0] nm;
    int         p;
    m_sp = 1'b0;
    m_fd = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0; m_leds = 8'h00; m_step = 3'd0; m_cnt = 0; m_mode = 2'd0; m_lfsr = SEED;
    end else if (ena) begin
      if (!m_run) begin
        m_leds = 8'h00; m_cnt = 0; m_step = 3'd0;
        if (run) begin
          m_run  = 1'b1;
          m_mode = mode;
          m_leds = (mode == 2'd3) ? m_lfsr : ref_frame(mode, 3'd0);
        end
      end else if (!run) begin
        m_run = 1'b0; m_leds = 8'h00; m_cnt = 0; m_step = 3'd0;
      end else begin
        p = TICK_DIV << speed;
        if (m_cnt >= p - 1) begin
          m_cnt = 0;
          m_sp  = 1'b1;
          if (m_mode == 2'd3) m_lfsr = ref_lfsr_next(m_lfsr);
          if (m_step < 3'd7) begin
            m_step++;
            m_leds = (m_mode == 2'd3) ? m_lfsr : ref_frame(m_mode, m_step);
          end else begin
            m_fd   = 1'b1;
            m_step = 3'd0;
            nm     = auto_cycle ? (m_mode + 2'd1) : mode;
            m_mode = nm;
            m_leds = (nm == 2'd3) ? m_lfsr : ref_frame(nm, 3'd0);
          end
        end else begin
          m_cnt++;
        end
      end
    end
    e.leds = m_leds; e.sp = m_sp; e.fd = m_fd; e.busy = m_run;
    sb_q.push_back(e);
  endtask

  // One clock: predict, let the edge happen, then pop and compare away from the edge.
  task automatic cyc();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    cyc_cnt++;
    e = sb_q.pop_front();
    chk("leds", leds, e.leds);
    chk("step_pulse", step_pulse, e.sp);
    chk("frame_done", frame_done, e.fd);
    chk("busy", busy, e.busy);
    if (step_pulse) begin
      obs_q.push_back(leds);
      last_gap      = cyc_cnt - last_pulse_at;
      last_pulse_at = cyc_cnt;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_pulse(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!step_pulse && k < max_cyc);
    chk({tag, "_timeout"}, step_pulse, 1'b1);
  endtask

  task automatic chk_tbl(input string tag, input logic [7:0] tbl [9]);
    chk({tag, "_count"}, obs_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < obs_q.size()) chk($sformatf("%s[%0d]", tag, i), obs_q[i], tbl[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; run = 1'b0; mode = 2'd0; auto_cycle = 1'b0; speed = 2'd0;
    run_cycles(2);
    chk("reset_leds", leds, 8'h00);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    run_cycles(2);

    // Chase at speed 0: 4-cycle steps, wrap back to 0x01 with frame_done.
    run = 1'b1; mode = 2'd0;
    cyc();
    obs_q.delete();
    obs_q.push_back(leds);
    run_cycles(32);
    chk_tbl("chase", chase_tbl);
    chk("chase_gap", last_gap, 4);

    // Fill at speed 2: 16-cycle steps.
    run = 1'b0;
    run_cycles(2);
    run = 1'b1; mode = 2'd1; speed = 2'd2;
    cyc();
    obs_q.delete();
    obs_q.push_back(leds);
    run_cycles(128);
    chk_tbl("fill", fill_tbl);
    chk("fill_gap", last_gap, 16);

    // Sparkle straight from reset uses the seeded LFSR.
    rst_n = 1'b0; run = 1'b0; speed = 2'd0;
    cyc();
    rst_n = 1'b1; run = 1'b1; mode = 2'd3;
    cyc();
    obs_q.delete();
    obs_q.push_back(leds);
    run_cycles(32);
    chk_tbl("sparkle", spark_tbl);

    // Auto-cycle through all modes; mode input changes must not matter.
    run = 1'b0;
    cyc();
    run = 1'b1; mode = 2'd0; auto_cycle = 1'b1;
    run_cycles(10);
    mode = 2'd2;
    run_cycles(60);
    mode = 2'd1;
    run_cycles(100);
    auto_cycle = 1'b0;

    // Drop run mid-frame.
    mode = 2'd0;
    run_cycles(6);
    run = 1'b0;
    cyc();
    chk("drop_leds", leds, 8'h00);
    chk("drop_busy", busy, 1'b0);

    // ena low for 10 cycles mid-step stretches that step by exactly 10.
    run = 1'b1;
    cyc();
    wait_pulse("ena_pre", 40);
    cyc();
    ena = 1'b0;
    run_cycles(10);
    ena = 1'b1;
    wait_pulse("ena_post", 40);
    chk("ena_gap", last_gap, 14);

    // Reset mid-sparkle, then restart from the seed.
    run = 1'b0;
    cyc();
    run = 1'b1; mode = 2'd3;
    run_cycles(11);
    rst_n = 1'b0;
    cyc();
    chk("rst_leds", leds, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk("restart_leds", leds, 8'h01);
    run_cycles(8);

    // Random traffic, including speed changes mid-step and ena gaps.
    for (int i = 0; i < 600; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      run = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) auto_cycle = ~auto_cycle;
      cyc();
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
